// File: rtl/exception_unit_if.sv
// exception_unit_if: cause/SPR bus between the execute-stage cause
// generators, the PC/SPR write-back logic and exception_unit.
// master drives causes, PCs and SPR accesses; slave is the exception unit.
interface exception_unit_if #(
  parameter int NCAUSE = 23,
  parameter int DATA_W = 32
);
  logic [NCAUSE-1:0] ca_in;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] next_pc;
  logic [DATA_W-1:0] ea;
  logic              eret;
  logic              sprw;
  logic [2:0]        reg_sel;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] spr_out;
  logic [NCAUSE-1:0] mca;
  logic              jisr;
  logic [4:0]        cause_id;
  logic              mode;
  logic              abort;
  logic              in_isr;

  modport master (
    output ca_in, pc, next_pc, ea, eret, sprw, reg_sel, data_in,
    input  spr_out, mca, jisr, cause_id, mode, abort, in_isr
  );

  modport slave (
    input  ca_in, pc, next_pc, ea, eret, sprw, reg_sel, data_in,
    output spr_out, mca, jisr, cause_id, mode, abort, in_isr
  );
endinterface

// File: rtl/exception_unit.sv
// exception_unit: latches sticky external causes, applies the SR mask,
// resolves priority (index 0 highest) and raises jisr with the cause id.
// Owns SR/ESR/ECA/EPC/EDPC/EDATA/MODE, guards against nested non-maskable
// causes inside the ISR (double fault -> HALT with sticky abort).
// Optional macro EXC_COUNT_EN: saturating 32-bit exception counter at SPR 7.
module exception_unit #(
  parameter int                NCAUSE    = 23,
  parameter int                MASK_BASE = 6,
  parameter int                EXT_BASE  = 16,
  parameter logic [NCAUSE-1:0] RPT_MASK  = 23'h12FFFE,
  parameter int                DATA_W    = 32
) (
  input logic             clk,
  input logic             rst,
  exception_unit_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISR, ST_HALT} state_t;

  localparam logic [NCAUSE-1:0] EXT_MASK = {NCAUSE{1'b1}} << EXT_BASE;

  state_t            r_state, w_state_nxt;
  logic [NCAUSE-1:0] r_pending, w_pending_nxt;
  logic [NCAUSE-1:0] w_mask, w_mca, w_clr, r_eca;
  logic [DATA_W-1:0] r_sr, r_esr, r_epc, r_edpc, r_edata;
  logic [DATA_W-1:0] w_spr_rd, w_cnt_rd;
  logic              r_mode, r_emode, r_abort;
  logic              w_jisr, w_rpt, w_wr_en;
  logic [4:0]        w_cause_id;

  // Mask vector: non-maskable causes always pass, the rest follow SR.
  always_comb begin
    w_mask = '1;
    for (int i = MASK_BASE; i < NCAUSE; i++) w_mask[i] = r_sr[i];
  end

  assign w_mca = (bus.ca_in | r_pending) & w_mask;

  // Priority encoder: lowest set bit wins; also look up its repeat/continue kind.
  always_comb begin
    w_cause_id = '0;
    w_rpt      = 1'b0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (w_mca[i]) begin
        w_cause_id = 5'(i);
        w_rpt      = RPT_MASK[i];
      end
    end
  end

  // Next-state and jisr: only non-maskable causes can fire inside the ISR.
  always_comb begin
    w_state_nxt = r_state;
    w_jisr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_jisr = |w_mca;
        if (w_jisr) w_state_nxt = ST_ISR;
      end
      ST_ISR: begin
        w_jisr = |w_mca[MASK_BASE-1:0];
        if (w_jisr)        w_state_nxt = ST_HALT;
        else if (bus.eret) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // SPR writes lose to jisr and are frozen once halted.
  assign w_wr_en = bus.sprw && (r_state != ST_HALT) && !w_jisr;

  // Pending clear: taken causes on jisr, plus ECA writes issued from the ISR.
  always_comb begin
    w_clr = w_jisr ? w_mca : '0;
    if (w_wr_en && (r_state == ST_ISR) && (bus.reg_sel == 3'd2))
      w_clr = w_clr | bus.data_in[NCAUSE-1:0];
    w_pending_nxt = (r_pending | bus.ca_in) & ~w_clr & EXT_MASK;
  end

  // Sticky pending register for external causes; frozen in HALT.
  always_ff @(posedge clk) begin
    if (rst)                     r_pending <= '0;
    else if (r_state != ST_HALT) r_pending <= w_pending_nxt;
  end

  // Exception SPRs: capture on entry, restore on eret, software writes otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_esr   <= '0;
      r_eca   <= '0;
      r_epc   <= '0;
      r_edpc  <= '0;
      r_edata <= '0;
      r_mode  <= 1'b0;
      r_emode <= 1'b0;
      r_abort <= 1'b0;
    end else if (w_jisr) begin
      if (r_state == ST_IDLE) begin
        r_eca   <= w_mca;
        r_esr   <= r_sr;
        r_emode <= r_mode;
        r_sr    <= '0;
        r_mode  <= 1'b0;
        r_edata <= bus.ea;
        r_epc   <= w_rpt ? bus.pc : bus.next_pc;
        r_edpc  <= bus.next_pc;
      end else begin
        r_abort <= 1'b1;
      end
    end else begin
      if (w_wr_en) begin
        case (bus.reg_sel)
          3'd0:    r_sr    <= bus.data_in;
          3'd1:    r_esr   <= bus.data_in;
          3'd2:    r_eca   <= bus.data_in[NCAUSE-1:0];
          3'd3:    r_epc   <= bus.data_in;
          3'd4:    r_edpc  <= bus.data_in;
          3'd5:    r_edata <= bus.data_in;
          3'd6:    r_mode  <= bus.data_in[0];
          default: ;
        endcase
      end
      // Placed after the write so eret overrides a same-cycle SR/MODE write.
      if ((r_state == ST_ISR) && bus.eret) begin
        r_sr   <= r_esr;
        r_mode <= r_emode;
      end
    end
  end

`ifdef EXC_COUNT_EN
  logic [31:0] r_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Exception counter: saturating count of jisr edges, loadable through SPR 7.
  always_ff @(posedge clk) begin
    if (rst)                                     r_cnt <= '0;
    else if (w_jisr)                             r_cnt <= sat_inc(r_cnt);
    else if (w_wr_en && (bus.reg_sel == 3'd7))   r_cnt <= bus.data_in[31:0];
  end

  assign w_cnt_rd = DATA_W'(r_cnt);
`else
  assign w_cnt_rd = '0;
`endif

  // SPR read mux.
  always_comb begin
    w_spr_rd = '0;
    case (bus.reg_sel)
      3'd0:    w_spr_rd = r_sr;
      3'd1:    w_spr_rd = r_esr;
      3'd2:    w_spr_rd = DATA_W'(r_eca);
      3'd3:    w_spr_rd = r_epc;
      3'd4:    w_spr_rd = r_edpc;
      3'd5:    w_spr_rd = r_edata;
      3'd6:    w_spr_rd = DATA_W'(r_mode);
      default: w_spr_rd = w_cnt_rd;
    endcase
  end

  assign bus.spr_out  = w_spr_rd;
  assign bus.mca      = w_mca;
  assign bus.jisr     = w_jisr;
  assign bus.cause_id = w_cause_id;
  assign bus.mode     = r_mode;
  assign bus.abort    = r_abort;
  assign bus.in_isr   = (r_state == ST_ISR);
endmodule
